// File: rtl/bin16_to_bcd4_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bin16_to_bcd4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int          BCD_DIGITS = 5;
    localparam int          BCD_W      = 4 * BCD_DIGITS;
    localparam int          BIN_W      = 16;
    localparam int          ITERS      = 16;
    localparam int          CNT_W      = 4;
    localparam logic [15:0] SAT_VALUE  = 16'h9999;

endpackage

// File: rtl/bin16_to_bcd4_bcd_dabble_step.sv
// One double-dabble correction: every BCD digit of 5 or more gets +3 before the shift.
module bcd_dabble_step
    import bin16_to_bcd4_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [BCD_W-1:0] bcd_o
);

    always_comb begin
        bcd_o = bcd_i;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_i[i*4 +: 4] >= 4'd5) begin
                bcd_o[i*4 +: 4] = bcd_i[i*4 +: 4] + 4'd3;
            end
        end
    end

endmodule

// File: rtl/bin16_to_bcd4.sv
// Sequential 16-bit binary to 4-digit BCD converter, one double-dabble bit per clock.
// Handshake: a transfer happens on a posedge where in_valid && in_ready; in_ready is
// high only while idle and not presenting a fresh result, so the next transfer is at
// least 18 cycles after the previous one. out_valid is a one-cycle pulse per result.
module bin16_to_bcd4
    import bin16_to_bcd4_pkg::*;
#(
    parameter bit SIGNED = 1'b0,
    parameter int DP_POS = 0,
    parameter bit DP_EN  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic [15:0] digits,
    output logic [1:0]  ones_place,
    output logic        dp_en,
    output logic        neg,
    output logic        ovf,
    output logic        out_valid,
    output state_t      dbg_state
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   mag_q, mag_d;
    logic               sign_q, sign_d;
    logic [15:0]        digits_q, digits_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+BIN_W-1:0] shifted;
    logic                   in_neg;

    bcd_dabble_step u_step (
        .bcd_i (bcd_q),
        .bcd_o (bcd_adj)
    );

    assign shifted = {bcd_adj, mag_q} << 1;
    assign in_neg  = SIGNED && in_data[15];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        mag_d       = mag_q;
        sign_d      = sign_q;
        digits_d    = digits_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    sign_d  = in_neg;
                    mag_d   = in_neg ? (~in_data) + 16'd1 : in_data;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                bcd_d = shifted[BCD_W+BIN_W-1:BIN_W];
                mag_d = shifted[BIN_W-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // A nonzero fifth digit means the magnitude exceeds the display range.
                if (bcd_q[BCD_W-1:16] != '0) begin
                    digits_d = SAT_VALUE;
                    ovf_d    = 1'b1;
                end else begin
                    digits_d = bcd_q[15:0];
                    ovf_d    = 1'b0;
                end
                neg_d       = sign_q;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bcd_q       <= '0;
            mag_q       <= '0;
            sign_q      <= 1'b0;
            digits_q    <= '0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            mag_q       <= mag_d;
            sign_q      <= sign_d;
            digits_q    <= digits_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE) && !out_valid_q;
    assign digits     = digits_q;
    assign neg        = neg_q;
    assign ovf        = ovf_q;
    assign out_valid  = out_valid_q;
    assign ones_place = 2'(DP_POS);
    assign dp_en      = DP_EN;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_bin16_to_bcd4.sv
// Bench for bin16_to_bcd4: an unsigned instance (DP_POS=2, DP_EN=1) and a signed instance
// share one stimulus stream; each has its own expected queue checked by a monitor.
module tb_bin16_to_bcd4;
    import bin16_to_bcd4_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;

    logic        in_ready_u, dp_en_u, neg_u, ovf_u, out_valid_u;
    logic [15:0] digits_u;
    logic [1:0]  ones_place_u;
    state_t      state_u;
    logic        in_ready_s, dp_en_s, neg_s, ovf_s, out_valid_s;
    logic [15:0] digits_s;
    logic [1:0]  ones_place_s;
    state_t      state_s;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    // Expected entries are {neg, ovf, digits}; latency queues hold the expected cycle.
    logic [17:0] exp_q_u[$];
    logic [17:0] exp_q_s[$];
    int          lat_q_u[$];
    int          lat_q_s[$];
    logic [17:0] last_u = 18'h0;
    logic [17:0] last_s = 18'h0;

    bin16_to_bcd4 #(.SIGNED(1'b0), .DP_POS(2), .DP_EN(1'b1)) u_dut_u (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready_u),
        .digits     (digits_u),
        .ones_place (ones_place_u),
        .dp_en      (dp_en_u),
        .neg        (neg_u),
        .ovf        (ovf_u),
        .out_valid  (out_valid_u),
        .dbg_state  (state_u)
    );

    bin16_to_bcd4 #(.SIGNED(1'b1), .DP_POS(0), .DP_EN(1'b0)) u_dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready_s),
        .digits     (digits_s),
        .ones_place (ones_place_s),
        .dp_en      (dp_en_s),
        .neg        (neg_s),
        .ovf        (ovf_s),
        .out_valid  (out_valid_s),
        .dbg_state  (state_s)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [17:0] model(input logic [15:0] v, input bit sgn);
        int m;
        bit n;
        n = sgn && (int'(v) >= 32768);
        m = n ? 65536 - int'(v) : int'(v);
        if (m > 9999) return {n, 1'b1, 16'h9999};
        return {n, 1'b0, 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic [15:0] v);
        bit done;
        done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        for (int i = 0; i < 100 && !done; i++) begin
            if (in_ready_u) begin
                exp_q_u.push_back(model(v, 1'b0));
                exp_q_s.push_back(model(v, 1'b1));
                lat_q_u.push_back(cyc + 18);
                lat_q_s.push_back(cyc + 18);
                done = 1'b1;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'(($urandom));
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((exp_q_u.size() != 0 || exp_q_s.size() != 0) && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("drain_timeout", 32'(exp_q_u.size() + exp_q_s.size()), 32'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic mon(input bit sgn, input logic ov, input logic [15:0] dg, input logic ng,
                       input logic of, input logic rdy);
        logic [17:0] e;
        int          lat;
        if (ov) begin
            if ((sgn ? exp_q_s.size() : exp_q_u.size()) == 0) begin
                check(sgn ? "spurious_out_valid_s" : "spurious_out_valid_u", 32'd1, 32'd0);
            end else begin
                e   = sgn ? exp_q_s.pop_front() : exp_q_u.pop_front();
                lat = sgn ? lat_q_s.pop_front() : lat_q_u.pop_front();
                check(sgn ? "digits_s" : "digits_u", 32'(dg), 32'(e[15:0]));
                check(sgn ? "ovf_s" : "ovf_u", 32'(of), 32'(e[16]));
                check(sgn ? "neg_s" : "neg_u", 32'(ng), 32'(e[17]));
                check(sgn ? "latency_s" : "latency_u", 32'(cyc), 32'(lat));
                check(sgn ? "ready_low_at_commit_s" : "ready_low_at_commit_u", 32'(rdy), 32'd0);
                if (sgn) last_s = e; else last_u = e;
            end
        end else begin
            e = sgn ? last_s : last_u;
            check(sgn ? "hold_s" : "hold_u", 32'({ng, of, dg}), 32'(e));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(1'b0, out_valid_u, digits_u, neg_u, ovf_u, in_ready_u);
            mon(1'b1, out_valid_s, digits_s, neg_s, ovf_s, in_ready_s);
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_ready_u"}, 32'(in_ready_u), 32'd1);
        check({tag, "_ready_s"}, 32'(in_ready_s), 32'd1);
        check({tag, "_out_u"}, 32'({out_valid_u, neg_u, ovf_u, digits_u}), 32'd0);
        check({tag, "_out_s"}, 32'({out_valid_s, neg_s, ovf_s, digits_s}), 32'd0);
    endtask

    task automatic check_consts(input string tag);
        check({tag, "_dp_u"}, 32'({ones_place_u, dp_en_u}), 32'({2'd2, 1'b1}));
        check({tag, "_dp_s"}, 32'({ones_place_s, dp_en_s}), 32'({2'd0, 1'b0}));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] directed[12];
        directed = '{16'd1234, 16'd65535, 16'd9999, 16'd0, 16'hFFFF, 16'h8000,
                     16'd10000, 16'd32767, 16'hD8F1, 16'hD8F0, 16'd1, 16'd5000};

        #1;
        check_reset_state("reset");
        check_consts("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            send(directed[i]);
            idle(int'($urandom_range(0, 3)));
        end
        drain();
        check_consts("after_directed");

        // in_valid held high across back-to-back values
        send(16'd42);
        send(16'd7);
        idle(1);
        drain();

        for (int i = 0; i < 40; i++) begin
            send(16'($urandom_range(0, 65535)));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 4)));
        end
        idle(1);
        drain();

        // reset in the middle of a conversion
        send(16'd1234);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midconv_reset");
        exp_q_u.delete();
        exp_q_s.delete();
        lat_q_u.delete();
        lat_q_s.delete();
        last_u = 18'h0;
        last_s = 18'h0;
        @(negedge clk);
        rst_n = 1'b1;
        send(16'd500);
        idle(1);
        drain();
        check_consts("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
